nor_seq_exec: RTL and testbench
===============================

Name: nor_seq_exec

Overview:
Sequential executor for technology-mapped NOR/INV netlists, evaluated the way a MAGIC-style memristive crossbar row would evaluate them. It consumes the instruction stream produced from a mapped inv1/nor2/nor3 netlist and retires one gate per cycle into a bit-cell array. It sits directly downstream of the mapping flow and returns selected cell values on a result handshake.
- NOR may only pull a cell from 1 to 0, so the destination must first be INIT'd.

Parameters:
NCELL, 16, number of 1-bit cells in the array.
AW, $clog2(NCELL), cell address width (derived; do not override).
CW, 16, width of the NOR-operation counter.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  instruction valid.
in_ready  out  1  instruction accepted when in_valid & in_ready.
in_op  in  2  0=INIT, 1=NOR, 2=LOAD, 3=READ.
in_dst  in  AW  destination cell (INIT/NOR/LOAD).
in_src_a  in  AW  source 0 (NOR), read address (READ).
in_src_b  in  AW  source 1 (NOR).
in_src_c  in  AW  source 2 (NOR).
in_mask  in  3  NOR source enables [0]=a [1]=b [2]=c; inv1=001, nor2=011, nor3=111.
in_data  in  1  LOAD value.
res_valid  out  1  READ result valid.
res_ready  in  1  result consumer ready.
res_data  out  1  READ result bit.
err  out  1  sticky protocol error.
nor_count  out  CW  NOR instructions retired, saturating.

Behaviour:
- Reset:
  - All cells 0; all per-cell init flags 0.
  - res_valid=0, res_data=0, err=0, nor_count=0.
  - in_ready=0 while rst is high.
- in_ready = !rst & !(res_valid & !res_ready).
- Exactly one instruction retires per accepted cycle.
- Writes land at the clock edge of acceptance. The next instruction reads the updated array, so there are no hazards and no bypass is needed.
- INIT: cell[dst]<=1; flag[dst]<=1.
- LOAD: cell[dst]<=in_data; flag[dst]<=0.
- NOR:
  - or = OR of cell[src_x] for each enabled mask bit.
  - cell[dst] <= cell[dst] & ~or; flag[dst]<=0.
  - nor_count += 1, saturating at all-ones.
  - in_mask=000 gives or=0: dst unchanged, still counted, flag still cleared.
- NOR error conditions (the cell update is still applied as specified; err <= 1):
  - flag[dst]==0, i.e. dst not INIT'd since its last write.
  - Any enabled source address equal to dst.
- READ:
  - res_data <= cell[src_a]; res_valid <= 1 on the edge after acceptance.
  - res_valid and res_data hold stable until res_valid & res_ready.
  - A READ accepted in the same cycle that the old result is consumed loads the new result; res_valid stays 1.
- Addresses >= NCELL (non-power-of-2 NCELL):
  - Instruction is a no-op.
  - err <= 1.
  - A READ still returns res_data=0 with res_valid handshake.
- err and nor_count clear only on rst.
- Reset asserted mid-stream:
  - All state returns to reset values asynchronously.
  - A pending result is dropped.
  - No instruction retires on the edge where rst is high.
- Result path FSM:
  - EMPTY -> FULL on READ accept.
  - FULL -> EMPTY on res_ready when no new READ is accepted.
  - FULL -> FULL on res_ready with a new READ accepted.

Decomposition:
- Shared package nor_seq_pkg holds:
  - op_e enum (OP_INIT, OP_NOR, OP_LOAD, OP_READ).
  - instr_t struct (op, dst, src_a, src_b, src_c, mask, data).
  - Mask constants MASK_INV1=3'b001, MASK_NOR2=3'b011, MASK_NOR3=3'b111.
- One sub-module, nor_cell_array:
  - NCELL cells plus init flags.
  - Three combinational read ports and one write port with masked-NOR update.
  - Async reset.
- Handshake, error checks and counter stay in nor_seq_exec.

Test Plan:
- Basic program: LOAD c0=1, LOAD c1=0, INIT c2, NOR c2<=nor2(c0,c1), READ c2 -> res_data=0, err=0, nor_count=1.
- 5-input mapped program:
  - LOAD a..e = 1,1,1,0,1 into c0..c4, then run the 10-gate inv1/nor2/nor3 sequence with an INIT before each gate.
  - Compute f = ~d & ((a|b)&c&e | a&b&(c|e)); READ -> f=1, nor_count=10.
  - Repeat with d=1 -> f=0.
- Missing INIT: LOAD c5=0, NOR c5<=inv1(c0=0) -> cell stays 0, err=1 and sticky through later legal ops.
- Back-pressure:
  - Hold res_ready=0, issue READ c0 then another READ -> in_ready=0 after the first; res_data stays stable.
  - Raise res_ready -> second READ accepted the same cycle; res_valid stays 1 with the new value.
- Src equals dst: INIT c3, NOR c3<=nor2(c3,c0) -> err=1.
- Reset mid-op: assert rst while res_valid=1 and nor_count=7 -> res_valid=0, nor_count=0, all cells read 0 after release.
- Counter: CW=4, issue 17 NORs -> nor_count=15.

Source files
------------

// File: rtl/nor_seq_pkg.sv
// nor_seq_pkg
// Shared types and constants for the NOR/INV sequential executor.
//   op_e      : instruction opcode (INIT, NOR, LOAD, READ)
//   instr_t   : decoded instruction, addresses held at ADDR_MAX_W bits
//   MASK_*    : source-enable patterns for inv1 / nor2 / nor3 gates
//   addr_ok() : true when an address falls inside an NCELL-entry array
package nor_seq_pkg;

  // Widest cell address the decoded instruction record can carry, which
  // limits the executor to at most 256 cells.
  localparam int ADDR_MAX_W = 8;

  typedef logic [ADDR_MAX_W-1:0] addr_t;

  typedef enum logic [1:0] {
    OP_INIT = 2'd0,
    OP_NOR  = 2'd1,
    OP_LOAD = 2'd2,
    OP_READ = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    addr_t      dst;
    addr_t      src_a;
    addr_t      src_b;
    addr_t      src_c;
    logic [2:0] mask;
    logic       data;
  } instr_t;

  localparam logic [2:0] MASK_INV1 = 3'b001;
  localparam logic [2:0] MASK_NOR2 = 3'b011;
  localparam logic [2:0] MASK_NOR3 = 3'b111;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  function automatic logic addr_ok(input addr_t addr, input int ncell);
    return int'(addr) < ncell;
  endfunction

endpackage

// File: rtl/nor_cell_array.sv
// nor_cell_array
// NCELL one-bit cells, each with an "initialised" flag, modelled after a
// memristive crossbar row. Three combinational read ports feed the NOR
// sources; one write port applies INIT / LOAD / masked-NOR updates.
//   clk, rst                : clock, async active-high reset (clears all)
//   rd_addr_x / rd_data_x   : combinational read ports a, b, c
//   wr_en, wr_op, wr_addr   : write strobe, opcode (op_e encoding), target
//   wr_mask, wr_data        : NOR source enables, LOAD value
//   wr_cell, wr_flag        : current value and init flag of the target
module nor_cell_array
  import nor_seq_pkg::*;
#(
  parameter int NCELL = 16,
  parameter int AW    = $clog2(NCELL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [AW-1:0] rd_addr_c,
  output logic          rd_data_a,
  output logic          rd_data_b,
  output logic          rd_data_c,
  input  logic          wr_en,
  input  logic [1:0]    wr_op,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_mask,
  input  logic          wr_data,
  output logic          wr_cell,
  output logic          wr_flag
);

  localparam logic [AW:0] NCELL_LIM = NCELL[AW:0];

  logic [NCELL-1:0] cells;
  logic [NCELL-1:0] flags;
  logic             src_or;

  // Addresses past the last cell (non-power-of-2 NCELL) read as 0.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < NCELL_LIM;
  endfunction

  assign rd_data_a = in_range(rd_addr_a) ? cells[rd_addr_a] : 1'b0;
  assign rd_data_b = in_range(rd_addr_b) ? cells[rd_addr_b] : 1'b0;
  assign rd_data_c = in_range(rd_addr_c) ? cells[rd_addr_c] : 1'b0;
  assign wr_cell   = in_range(wr_addr)   ? cells[wr_addr]   : 1'b0;
  assign wr_flag   = in_range(wr_addr)   ? flags[wr_addr]   : 1'b0;

  // Only enabled sources take part in the OR; an all-zero mask leaves it 0.
  assign src_or = |(wr_mask & {rd_data_c, rd_data_b, rd_data_a});

  // NOR can only pull a cell from 1 to 0, hence the AND with its old value.
  // Any write other than INIT leaves the cell un-initialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells <= '0;
      flags <= '0;
    end else if (wr_en) begin
      case (wr_op)
        OP_INIT: begin
          cells[wr_addr] <= 1'b1;
          flags[wr_addr] <= 1'b1;
        end
        OP_LOAD: begin
          cells[wr_addr] <= wr_data;
          flags[wr_addr] <= 1'b0;
        end
        OP_NOR: begin
          cells[wr_addr] <= wr_cell & ~src_or;
          flags[wr_addr] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nor_seq_exec.sv
// nor_seq_exec
// Retires one INIT / NOR / LOAD / READ instruction per accepted cycle into
// a nor_cell_array, returns READ results on a valid/ready handshake, flags
// protocol errors and counts retired NOR gates.
//   clk, rst                 : clock, async active-high reset
//   in_valid / in_ready      : instruction handshake
//   in_op, in_dst, in_src_*  : opcode and cell addresses
//   in_mask, in_data         : NOR source enables, LOAD value
//   res_valid / res_ready    : READ result handshake, res_data the bit
//   err                      : sticky protocol error
//   nor_count                : saturating count of retired NORs
module nor_seq_exec
  import nor_seq_pkg::*;
#(
  parameter int NCELL = 16,
  parameter int AW    = $clog2(NCELL),
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [AW-1:0] in_dst,
  input  logic [AW-1:0] in_src_a,
  input  logic [AW-1:0] in_src_b,
  input  logic [AW-1:0] in_src_c,
  input  logic [2:0]    in_mask,
  input  logic          in_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_data,
  output logic          err,
  output logic [CW-1:0] nor_count
);

  instr_t     ins;
  res_state_e res_state;
  res_state_e res_next;
  logic       accept;
  logic       retire;
  logic       addr_err;
  logic       alias_err;
  logic       nor_err;
  logic       wr_en;
  logic       read_acc;
  logic       load_res;
  logic       rd_data_a;
  logic       rd_data_b;
  logic       rd_data_c;
  logic       wr_cell;
  logic       wr_flag;

  assign ins = '{
    op:    op_e'(in_op),
    dst:   addr_t'(in_dst),
    src_a: addr_t'(in_src_a),
    src_b: addr_t'(in_src_b),
    src_c: addr_t'(in_src_c),
    mask:  in_mask,
    data:  in_data
  };

  assign res_valid = (res_state == RES_FULL);
  assign in_ready  = !rst && !(res_valid && !res_ready);
  assign accept    = in_valid && in_ready;

  // Out-of-range checks cover only the addresses the opcode actually uses;
  // for NOR that means the destination plus the enabled sources.
  always_comb begin
    addr_err = 1'b0;
    case (ins.op)
      OP_INIT, OP_LOAD: addr_err = !addr_ok(ins.dst, NCELL);
      OP_NOR: addr_err = !addr_ok(ins.dst, NCELL)
                       || (ins.mask[0] && !addr_ok(ins.src_a, NCELL))
                       || (ins.mask[1] && !addr_ok(ins.src_b, NCELL))
                       || (ins.mask[2] && !addr_ok(ins.src_c, NCELL));
      OP_READ: addr_err = !addr_ok(ins.src_a, NCELL);
      default: addr_err = 1'b0;
    endcase
  end

  // A NOR whose destination is also one of its enabled sources, or whose
  // destination was not INIT'd, is still applied but raises err.
  assign alias_err = (ins.mask[0] && ins.src_a == ins.dst)
                  || (ins.mask[1] && ins.src_b == ins.dst)
                  || (ins.mask[2] && ins.src_c == ins.dst);
  assign nor_err   = (ins.op == OP_NOR) && (!wr_flag || alias_err);

  // Bad-address instructions are no-ops apart from err and a READ's zero
  // result.
  assign retire   = accept && !addr_err;
  assign wr_en    = retire && (ins.op != OP_READ);
  assign read_acc = accept && (ins.op == OP_READ);

  nor_cell_array #(
    .NCELL (NCELL),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (in_src_a),
    .rd_addr_b (in_src_b),
    .rd_addr_c (in_src_c),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_data_c (rd_data_c),
    .wr_en     (wr_en),
    .wr_op     (in_op),
    .wr_addr   (in_dst),
    .wr_mask   (in_mask),
    .wr_data   (in_data),
    .wr_cell   (wr_cell),
    .wr_flag   (wr_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && (addr_err || nor_err)) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nor_count <= '0;
    end else if (retire && ins.op == OP_NOR && nor_count != '1) begin
      nor_count <= nor_count + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_state <= RES_EMPTY;
    end else begin
      res_state <= res_next;
    end
  end

  // A READ can only be accepted while FULL if the old result is being
  // consumed on the same edge, so FULL->FULL simply reloads the data.
  always_comb begin
    res_next = res_state;
    load_res = 1'b0;
    case (res_state)
      RES_EMPTY: begin
        if (read_acc) begin
          res_next = RES_FULL;
          load_res = 1'b1;
        end
      end
      RES_FULL: begin
        if (read_acc) begin
          res_next = RES_FULL;
          load_res = 1'b1;
        end else if (res_ready) begin
          res_next = RES_EMPTY;
        end
      end
      default: res_next = RES_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= 1'b0;
    end else if (load_res) begin
      res_data <= addr_err ? 1'b0 : rd_data_a;
    end
  end

endmodule

// File: tb/tb_nor_seq_exec.sv
// tb_nor_seq_exec
// Drives two executors from one instruction bus: a 16-cell, 16-bit-counter
// instance and a 12-cell, 4-bit-counter instance (out-of-range addresses
// and counter saturation). Both are compared each cycle against a
// behavioural model of the cell array and result handshake.
module tb_nor_seq_exec;
  import nor_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_op = 2'd0;
  logic [3:0] in_dst = 4'd0;
  logic [3:0] in_src_a = 4'd0;
  logic [3:0] in_src_b = 4'd0;
  logic [3:0] in_src_c = 4'd0;
  logic [2:0] in_mask = 3'd0;
  logic       in_data = 1'b0;
  logic       res_ready = 1'b1;

  logic        rdy0, rv0, rd0, err0;
  logic        rdy1, rv1, rd1, err1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int checks = 0;
  int failures = 0;

  // Reference state, index 0 = 16-cell DUT, index 1 = 12-cell DUT
  int ncell [2] = '{16, 12};
  int cmax  [2] = '{65535, 15};
  bit m_cell [2][16];
  bit m_flag [2][16];
  bit m_err  [2];
  int m_cnt  [2];
  bit m_rv   [2];
  bit m_rd   [2];

  nor_seq_exec #(.NCELL(16), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_op(in_op), .in_dst(in_dst), .in_src_a(in_src_a),
    .in_src_b(in_src_b), .in_src_c(in_src_c), .in_mask(in_mask),
    .in_data(in_data), .res_valid(rv0), .res_ready(res_ready),
    .res_data(rd0), .err(err0), .nor_count(cnt0)
  );

  nor_seq_exec #(.NCELL(12), .CW(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_op(in_op), .in_dst(in_dst), .in_src_a(in_src_a),
    .in_src_b(in_src_b), .in_src_c(in_src_c), .in_mask(in_mask),
    .in_data(in_data), .res_valid(rv1), .res_ready(res_ready),
    .res_data(rd1), .err(err1), .nor_count(cnt1)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Guard against a stuck handshake hanging the run
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_cell[k][i] = 1'b0;
        m_flag[k][i] = 1'b0;
      end
      m_err[k] = 1'b0;
      m_cnt[k] = 0;
      m_rv[k]  = 1'b0;
      m_rd[k]  = 1'b0;
    end
  endtask

  // Apply one clock edge to the reference model: retire the accepted
  // instruction (if any) and advance the result handshake.
  task automatic modelEdge(input bit acc);
    for (int k = 0; k < 2; k++) begin
      bit consumed, newread, bad, orv;
      int d, a, b, c;
      d = int'(in_dst); a = int'(in_src_a); b = int'(in_src_b); c = int'(in_src_c);
      consumed = m_rv[k] && res_ready;
      newread  = 1'b0;
      if (acc) begin
        bad = 1'b0;
        case (in_op)
          2'd0, 2'd2: bad = (d >= ncell[k]);
          2'd1: bad = (d >= ncell[k]) || (in_mask[0] && a >= ncell[k])
                   || (in_mask[1] && b >= ncell[k]) || (in_mask[2] && c >= ncell[k]);
          default: bad = (a >= ncell[k]);
        endcase
        if (bad) begin
          m_err[k] = 1'b1;
          if (in_op == 2'd3) begin
            m_rd[k] = 1'b0;
            newread = 1'b1;
          end
        end else begin
          case (in_op)
            2'd0: begin m_cell[k][d] = 1'b1; m_flag[k][d] = 1'b1; end
            2'd2: begin m_cell[k][d] = in_data; m_flag[k][d] = 1'b0; end
            2'd1: begin
              orv = (in_mask[0] && m_cell[k][a]) || (in_mask[1] && m_cell[k][b])
                 || (in_mask[2] && m_cell[k][c]);
              if (!m_flag[k][d] || (in_mask[0] && a == d) || (in_mask[1] && b == d)
                  || (in_mask[2] && c == d))
                m_err[k] = 1'b1;
              m_cell[k][d] = m_cell[k][d] && !orv;
              m_flag[k][d] = 1'b0;
              if (m_cnt[k] < cmax[k]) m_cnt[k]++;
            end
            default: begin m_rd[k] = m_cell[k][a]; newread = 1'b1; end
          endcase
        end
      end
      if (newread) m_rv[k] = 1'b1;
      else if (consumed) m_rv[k] = 1'b0;
    end
  endtask

  // One cycle: compare outputs at the falling edge, then let the model
  // follow the rising edge. Reports whether the bus was accepted.
  task automatic stepCycle(output bit acc);
    bit m_ready;
    @(negedge clk);
    m_ready = !(m_rv[0] && !res_ready);
    checkOutput("in_ready0", rdy0, m_ready);
    checkOutput("in_ready1", rdy1, m_ready);
    checkOutput("res_valid0", rv0, m_rv[0]);
    checkOutput("res_valid1", rv1, m_rv[1]);
    if (m_rv[0]) checkOutput("res_data0", rd0, m_rd[0]);
    if (m_rv[1]) checkOutput("res_data1", rd1, m_rd[1]);
    checkOutput("err0", err0, m_err[0]);
    checkOutput("err1", err1, m_err[1]);
    checkOutput("nor_count0", cnt0, m_cnt[0]);
    checkOutput("nor_count1", cnt1, m_cnt[1]);
    acc = in_valid && m_ready;
    @(posedge clk);
    modelEdge(acc);
    #1;
  endtask

  // Present one instruction and hold it until accepted; the result
  // consumer is forced ready after a few stalled cycles so the bus drains.
  task automatic applyStimulus(input logic [1:0] op, input int dst, input int a,
                               input int b, input int c, input logic [2:0] mask,
                               input logic data);
    bit acc, done;
    in_op = op; in_dst = 4'(dst); in_src_a = 4'(a); in_src_b = 4'(b);
    in_src_c = 4'(c); in_mask = mask; in_data = data; in_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (n == 4) res_ready = 1'b1;
      stepCycle(acc);
      done = acc;
    end
    checkOutput("accept_timeout", done, 1);
    in_valid = 1'b0;
  endtask

  task automatic gate(input int dst, input int a, input int b, input int c,
                      input logic [2:0] mask);
    applyStimulus(OP_INIT, dst, 0, 0, 0, 3'b000, 1'b0);
    applyStimulus(OP_NOR, dst, a, b, c, mask, 1'b0);
  endtask

  // Raise reset between clock edges and check the asynchronous clear
  task automatic resetAll();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput("rst_in_ready0", rdy0, 0);
    checkOutput("rst_res_valid0", rv0, 0);
    checkOutput("rst_res_data0", rd0, 0);
    checkOutput("rst_err0", err0, 0);
    checkOutput("rst_nor_count0", cnt0, 0);
    checkOutput("rst_res_valid1", rv1, 0);
    checkOutput("rst_nor_count1", cnt1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Five-input mapped program: gates n1..n10 land in c5..c14, f in c14
  task automatic runFive(input bit va, input bit vb, input bit vc,
                         input bit vd, input bit ve);
    int gd [10] = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    int ga [10] = '{0, 2, 4, 5, 0, 1, 2, 9, 8, 3};
    int gb [10] = '{1, 0, 0, 6, 0, 0, 4, 10, 12, 13};
    int gc [10] = '{0, 0, 0, 7, 0, 0, 0, 11, 0, 0};
    logic [2:0] gm [10] = '{MASK_NOR2, MASK_INV1, MASK_INV1, MASK_NOR3, MASK_INV1,
                            MASK_INV1, MASK_NOR2, MASK_NOR3, MASK_NOR2, MASK_NOR2};
    bit f;
    resetAll();
    res_ready = 1'b1;
    applyStimulus(OP_LOAD, 0, 0, 0, 0, 3'b000, va);
    applyStimulus(OP_LOAD, 1, 0, 0, 0, 3'b000, vb);
    applyStimulus(OP_LOAD, 2, 0, 0, 0, 3'b000, vc);
    applyStimulus(OP_LOAD, 3, 0, 0, 0, 3'b000, vd);
    applyStimulus(OP_LOAD, 4, 0, 0, 0, 3'b000, ve);
    for (int g = 0; g < 10; g++) gate(gd[g], ga[g], gb[g], gc[g], gm[g]);
    applyStimulus(OP_READ, 0, 14, 0, 0, 3'b000, 1'b0);
    f = !vd && (((va || vb) && vc && ve) || (va && vb && (vc || ve)));
    checkOutput("five_f", rd0, f);
    checkOutput("five_valid", rv0, 1);
    checkOutput("five_count", cnt0, 10);
    checkOutput("five_err", err0, 0);
  endtask

  initial begin
    bit acc;
    int r, d, a, b, c;
    $display("[TB] starting nor_seq_exec bench");
    #3;

    // Basic program: c2 <= nor2(1, 0) = 0
    resetAll();
    res_ready = 1'b1;
    applyStimulus(OP_LOAD, 0, 0, 0, 0, 3'b000, 1'b1);
    applyStimulus(OP_LOAD, 1, 0, 0, 0, 3'b000, 1'b0);
    gate(2, 0, 1, 0, MASK_NOR2);
    applyStimulus(OP_READ, 0, 2, 0, 0, 3'b000, 1'b0);
    checkOutput("basic_data", rd0, 0);
    checkOutput("basic_valid", rv0, 1);
    checkOutput("basic_err", err0, 0);
    checkOutput("basic_count", cnt0, 1);

    runFive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    runFive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Missing INIT: err raised and sticky through later legal ops
    resetAll();
    applyStimulus(OP_LOAD, 0, 0, 0, 0, 3'b000, 1'b0);
    applyStimulus(OP_LOAD, 5, 0, 0, 0, 3'b000, 1'b0);
    applyStimulus(OP_NOR, 5, 0, 0, 0, MASK_INV1, 1'b0);
    applyStimulus(OP_READ, 0, 5, 0, 0, 3'b000, 1'b0);
    checkOutput("noinit_cell", rd0, 0);
    checkOutput("noinit_err", err0, 1);
    gate(6, 0, 0, 0, MASK_INV1);
    applyStimulus(OP_READ, 0, 6, 0, 0, 3'b000, 1'b0);
    checkOutput("noinit_sticky", err0, 1);
    checkOutput("noinit_later_cell", rd0, 1);

    // Source aliasing the destination
    resetAll();
    applyStimulus(OP_LOAD, 0, 0, 0, 0, 3'b000, 1'b0);
    gate(3, 3, 0, 0, MASK_NOR2);
    applyStimulus(OP_READ, 0, 3, 0, 0, 3'b000, 1'b0);
    checkOutput("alias_err", err0, 1);
    checkOutput("alias_cell", rd0, 0);

    // Back-pressure: second READ waits until the first result is consumed
    resetAll();
    applyStimulus(OP_LOAD, 0, 0, 0, 0, 3'b000, 1'b1);
    applyStimulus(OP_LOAD, 1, 0, 0, 0, 3'b000, 1'b0);
    res_ready = 1'b0;
    applyStimulus(OP_READ, 0, 0, 0, 0, 3'b000, 1'b0);
    in_op = OP_READ; in_src_a = 4'd1; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      stepCycle(acc);
      checkOutput("bp_ready", rdy0, 0);
      checkOutput("bp_hold_data", rd0, 1);
    end
    res_ready = 1'b1;
    stepCycle(acc);
    in_valid = 1'b0;
    checkOutput("bp_new_valid", rv0, 1);
    checkOutput("bp_new_data", rd0, 0);
    stepCycle(acc);
    checkOutput("bp_drained", rv0, 0);

    // Reset with a pending result and nor_count = 7
    resetAll();
    applyStimulus(OP_LOAD, 0, 0, 0, 0, 3'b000, 1'b0);
    for (int g = 1; g <= 7; g++) gate(g, 0, 0, 0, MASK_INV1);
    res_ready = 1'b0;
    applyStimulus(OP_READ, 0, 1, 0, 0, 3'b000, 1'b0);
    checkOutput("pre_rst_valid", rv0, 1);
    checkOutput("pre_rst_count", cnt0, 7);
    resetAll();
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(OP_READ, 0, i, 0, 0, 3'b000, 1'b0);
      checkOutput($sformatf("post_rst_cell%0d", i), rd0, 0);
    end

    // Counter saturation on the 4-bit instance
    resetAll();
    for (int g = 0; g < 17; g++) gate(2, 0, 0, 0, MASK_INV1);
    stepCycle(acc);
    checkOutput("count17_wide", cnt0, 17);
    checkOutput("count17_sat", cnt1, 15);

    // Randomized stream; INIT is usually issued just before a NOR
    resetAll();
    for (int n = 0; n < 400; n++) begin
      res_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 7);
      d = $urandom_range(0, 15); a = $urandom_range(0, 15);
      b = $urandom_range(0, 15); c = $urandom_range(0, 15);
      case (r)
        0, 1: applyStimulus(OP_LOAD, d, 0, 0, 0, 3'b000, 1'($urandom_range(0, 1)));
        2, 3, 4: gate(d, a, b, c, 3'($urandom_range(0, 7)));
        5: applyStimulus(OP_NOR, d, a, b, c, 3'($urandom_range(0, 7)), 1'b0);
        6: applyStimulus(OP_READ, 0, a, 0, 0, 3'b000, 1'b0);
        default: applyStimulus(OP_INIT, d, 0, 0, 0, 3'b000, 1'b0);
      endcase
    end
    res_ready = 1'b1;
    stepCycle(acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
